// File: rtl/if_id_stage_buf.sv
// ---------------------------------------------------------------------------
// if_id_stage_buf
//
// Two-entry elastic register sitting on the IF/ID pipeline boundary. Fetch
// hands over an instruction word and its PC through a valid/ready handshake.
// The buffer stores the word together with the incremented PC (in_pc + PC_INC).
// Decode takes words from the head entry through a second valid/ready
// handshake.
//
// A skid entry backs the head entry. When decode stalls in the same cycle that
// fetch is still presenting a word, that word is absorbed into the skid entry
// and is not lost. in_ready is derived only from stored state, so no
// combinational path runs from out_ready back to fetch.
//
// flush squashes both entries in one edge. Two saturating counters record
// backpressure and flush activity for performance debug.
//
// Parameters:
//   INS_W    instruction word width
//   PC_W     PC width
//   PC_INC   constant added to in_pc at capture (wraps modulo 2^PC_W)
//   NOP_INS  instruction shown to decode while no entry is valid
//   CNT_W    width of each event counter
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous, active-low; clears all state immediately
//   in_valid   fetch presents a word
//   in_ins     fetched instruction
//   in_pc      PC of the fetched instruction
//   in_ready   buffer can accept a word this cycle
//   out_valid  head entry valid toward decode
//   out_ins    head instruction, NOP_INS when out_valid=0
//   out_pc     head incremented PC, 0 when out_valid=0
//   out_ready  decode consumes the head entry this cycle
//   flush      squash all entries (branch/exception redirect)
//   cnt_clr    synchronous clear of both event counters
//   occupancy  number of valid entries (0..2)
//   stall_cnt  cycles with out_valid=1 and out_ready=0 (saturating)
//   flush_cnt  flush cycles that found a nonzero occupancy (saturating)
// ---------------------------------------------------------------------------
module if_id_stage_buf #(
  parameter int unsigned       INS_W   = 32,
  parameter int unsigned       PC_W    = 32,
  parameter int unsigned       PC_INC  = 4,
  parameter logic [INS_W-1:0]  NOP_INS = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [INS_W-1:0] in_ins,
  input  logic [PC_W-1:0]  in_pc,
  output logic             in_ready,
  output logic             out_valid,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The state encodings equal the number of valid entries. This lets the
  // state register drive occupancy directly.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [PC_W-1:0]  PC_INC_W = PC_W'(PC_INC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic [INS_W-1:0] main_ins;
  logic [PC_W-1:0]  main_pc;
  logic [INS_W-1:0] skid_ins;
  logic [PC_W-1:0]  skid_pc;

  logic             accept;
  logic             pop;
  logic [PC_W-1:0]  cap_pc;

  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  logic             stall_hit;
  logic             flush_hit;

  // Handshake qualifiers. Both ready and valid come straight from the state
  // register. Because of this, out_ready never influences in_ready in the
  // same cycle.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;

  // A flush cycle never accepts. The word fetch presents during a redirect
  // belongs to the wrong path.
  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  // The PC is incremented once, at capture. Downstream then sees the PC of
  // the next sequential instruction, with wrap-around modulo 2^PC_W.
  assign cap_pc = in_pc + PC_INC_W;

  // Decode sees a clean bubble while the buffer is empty. Stale data never
  // leaks out of the head register.
  assign out_ins = out_valid ? main_ins : NOP_INS;
  assign out_pc  = out_valid ? main_pc  : '0;

  // Next-state and entry-load decisions.
  // In ONE, a simultaneous accept and pop writes the new word straight into
  // the head. This keeps the skid entry free, so the buffer sustains one word
  // per cycle. In FULL, a pop promotes the skid entry to head, which keeps the
  // order strictly FIFO.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase

    // A redirect empties the buffer regardless of the handshake. A pop in
    // the same cycle still counts as consumed from decode's point of view.
    if (flush) begin
      state_nxt = ST_EMPTY;
    end
  end

  // State register. Reset returns to EMPTY at once, so both entries are
  // discarded without any further handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Head entry. It is loaded either from fetch or from the skid entry. The
  // two sources are mutually exclusive by construction of the FSM above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_ins <= NOP_INS;
      main_pc  <= '0;
    end else if (load_main_in) begin
      main_ins <= in_ins;
      main_pc  <= cap_pc;
    end else if (load_main_skid) begin
      main_ins <= skid_ins;
      main_pc  <= skid_pc;
    end
  end

  // Skid entry. It is written only when decode stalls while the head is
  // occupied and fetch still delivers a word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_ins <= NOP_INS;
      skid_pc  <= '0;
    end else if (load_skid) begin
      skid_ins <= in_ins;
      skid_pc  <= cap_pc;
    end
  end

  // Event qualifiers for the performance counters. A flush counts only when
  // it actually squashed something.
  assign stall_hit = out_valid & ~out_ready;
  assign flush_hit = flush & (state != ST_EMPTY);

  // Stall counter. A clear wins over a same-cycle increment, and the count
  // sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_hit && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // Flush counter. It has the same clear priority and saturation as the
  // stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      flush_cnt <= '0;
    end else if (flush_hit && (flush_cnt != CNT_MAX)) begin
      flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_if_id_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage_buf
//
// Directed bench for if_id_stage_buf. Each table row drives one cycle of
// inputs. The row also carries hand-computed expectations for the state that
// is visible before that cycle's edge (occupancy, stall and flush counts).
//
// Every word the table expects the buffer to accept is pushed into a
// scoreboard queue as {ins, ins_pc + 4}. A separate monitor pops and compares
// whenever decode consumes the head.
//
// A second instance with CNT_W=2 shares the same stimulus. It exercises
// counter saturation.
// ---------------------------------------------------------------------------
module tb_if_id_stage_buf;

  localparam int unsigned       INS_W = 32;
  localparam int unsigned       PC_W  = 32;
  localparam logic [INS_W-1:0]  NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [INS_W-1:0] in_ins;
  logic [PC_W-1:0]  in_pc;
  logic             in_ready;
  logic             out_valid;
  logic [INS_W-1:0] out_ins;
  logic [PC_W-1:0]  out_pc;
  logic             out_ready;
  logic             flush;
  logic             cnt_clr;
  logic [1:0]       occupancy;
  logic [15:0]      stall_cnt;
  logic [15:0]      flush_cnt;

  logic             sat_in_ready;
  logic             sat_out_valid;
  logic [INS_W-1:0] sat_out_ins;
  logic [PC_W-1:0]  sat_out_pc;
  logic [1:0]       sat_occupancy;
  logic [1:0]       sat_stall_cnt;
  logic [1:0]       sat_flush_cnt;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        rdy;
    logic        fl;
    logic        clr;
    int          occ;
    int          st;
    int          fc;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  if_id_stage_buf #(
    .INS_W(INS_W), .PC_W(PC_W), .PC_INC(4), .NOP_INS(NOP), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ins(in_ins),
    .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid),
    .out_ins(out_ins), .out_pc(out_pc), .out_ready(out_ready),
    .flush(flush), .cnt_clr(cnt_clr), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_stage_buf #(
    .INS_W(INS_W), .PC_W(PC_W), .PC_INC(4), .NOP_INS(NOP), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ins(in_ins),
    .in_pc(in_pc), .in_ready(sat_in_ready), .out_valid(sat_out_valid),
    .out_ins(sat_out_ins), .out_pc(sat_out_pc), .out_ready(out_ready),
    .flush(flush), .cnt_clr(cnt_clr), .occupancy(sat_occupancy),
    .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt)
  );

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic v, input logic [31:0] ins,
                                  input logic [31:0] pc, input logic rdy,
                                  input logic fl, input logic clr,
                                  input int occ, input int st, input int fc);
    vec_t r;
    r.v = v; r.ins = ins; r.pc = pc; r.rdy = rdy; r.fl = fl; r.clr = clr;
    r.occ = occ; r.st = st; r.fc = fc;
    vecs.push_back(r);
  endfunction

  // Check the pre-edge state against the row, then drive the row's inputs.
  task automatic apply_stimulus(input vec_t r, input int idx);
    int   sat_st;
    exp_t e;
    @(posedge clk);
    #1;
    sat_st = (r.st > 3) ? 3 : r.st;
    check_output($sformatf("occupancy[%0d]", idx), 64'(occupancy), 64'(r.occ));
    check_output($sformatf("in_ready[%0d]", idx), 64'(in_ready), 64'(r.occ != 2));
    check_output($sformatf("stall_cnt[%0d]", idx), 64'(stall_cnt), 64'(r.st));
    check_output($sformatf("flush_cnt[%0d]", idx), 64'(flush_cnt), 64'(r.fc));
    check_output($sformatf("sat_stall_cnt[%0d]", idx), 64'(sat_stall_cnt), 64'(sat_st));
    check_output($sformatf("sat_flush_cnt[%0d]", idx), 64'(sat_flush_cnt), 64'(r.fc));
    in_valid  = r.v;
    in_ins    = r.ins;
    in_pc     = r.pc;
    out_ready = r.rdy;
    flush     = r.fl;
    cnt_clr   = r.clr;
    if (r.v && (r.occ != 2) && !r.fl) begin
      e.ins = r.ins;
      e.pc  = r.pc + 32'd4;
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check_output({tag, "_out_ins"}, 64'(out_ins), 64'(NOP));
    check_output({tag, "_out_pc"}, 64'(out_pc), 64'(0));
    check_output({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check_output({tag, "_occupancy"}, 64'(occupancy), 64'(0));
    check_output({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
    check_output({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(0));
  endtask

  // Monitor: inputs settle at posedge+1, so at the negedge a visible pop is
  // exactly what the next edge will consume.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pop: got pc %0h, expected no word", out_pc);
        end else begin
          mon_e = sb.pop_front();
          check_output("pop_ins", 64'(out_ins), 64'(mon_e.ins));
          check_output("pop_pc", 64'(out_pc), 64'(mon_e.pc));
        end
      end
      if (!out_valid) begin
        check_output("bubble_ins", 64'(out_ins), 64'(NOP));
        check_output("bubble_pc", 64'(out_pc), 64'(0));
      end
      if (flush) begin
        sb.delete();
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_ins = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    #2;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    //      v  ins           pc            rdy fl clr occ st fc
    // Streaming with decode always ready.
    add_vec(1, 32'hA1,       32'h100,      1, 0, 0,  0, 0, 0);  // r0
    add_vec(1, 32'hA2,       32'h104,      1, 0, 0,  1, 0, 0);  // r1
    add_vec(1, 32'hA3,       32'h108,      1, 0, 0,  1, 0, 0);  // r2
    add_vec(0, 32'h0,        32'h0,        1, 0, 0,  1, 0, 0);  // r3
    // Late stall: the second word lands in skid, then drains in order.
    add_vec(1, 32'hB1,       32'h200,      0, 0, 0,  0, 0, 0);  // r4
    add_vec(1, 32'hB2,       32'h204,      0, 0, 0,  1, 0, 0);  // r5
    add_vec(1, 32'hB3,       32'h208,      0, 0, 0,  2, 1, 0);  // r6
    add_vec(1, 32'hB3,       32'h208,      0, 0, 0,  2, 2, 0);  // r7
    add_vec(1, 32'hB3,       32'h208,      0, 0, 0,  2, 3, 0);  // r8
    add_vec(1, 32'hB3,       32'h208,      1, 0, 0,  2, 4, 0);  // r9
    add_vec(1, 32'hB3,       32'h208,      1, 0, 0,  1, 4, 0);  // r10
    add_vec(0, 32'h0,        32'h0,        1, 0, 0,  1, 4, 0);  // r11
    // Fill, then flush while FULL with a word on the input.
    add_vec(1, 32'hC1,       32'h300,      0, 0, 0,  0, 4, 0);  // r12
    add_vec(1, 32'hC2,       32'h304,      0, 0, 0,  1, 4, 0);  // r13
    add_vec(1, 32'hC3,       32'h308,      0, 1, 0,  2, 5, 0);  // r14
    add_vec(0, 32'h0,        32'h0,        0, 0, 0,  0, 6, 1);  // r15
    // Flush while empty, with and without an input word.
    add_vec(0, 32'h0,        32'h0,        1, 1, 0,  0, 6, 1);  // r16
    add_vec(1, 32'hD1,       32'h400,      1, 1, 0,  0, 6, 1);  // r17
    add_vec(0, 32'h0,        32'h0,        1, 0, 0,  0, 6, 1);  // r18
    // Pop and flush in the same cycle.
    add_vec(1, 32'hE1,       32'h500,      1, 0, 0,  0, 6, 1);  // r19
    add_vec(1, 32'hE2,       32'h504,      1, 1, 0,  1, 6, 1);  // r20
    add_vec(0, 32'h0,        32'h0,        1, 0, 0,  0, 6, 2);  // r21
    // Counter clear during an active stall.
    add_vec(1, 32'hF1,       32'h600,      0, 0, 0,  0, 6, 2);  // r22
    add_vec(0, 32'h0,        32'h0,        0, 0, 0,  1, 6, 2);  // r23
    add_vec(0, 32'h0,        32'h0,        0, 0, 1,  1, 7, 2);  // r24
    add_vec(0, 32'h0,        32'h0,        0, 0, 0,  1, 0, 0);  // r25
    add_vec(0, 32'h0,        32'h0,        1, 0, 0,  1, 1, 0);  // r26
    add_vec(0, 32'h0,        32'h0,        1, 0, 0,  0, 1, 0);  // r27
    // Fill before a mid-stream reset.
    add_vec(1, 32'h71,       32'h700,      0, 0, 0,  0, 1, 0);  // r28
    add_vec(1, 32'h72,       32'h704,      0, 0, 0,  1, 1, 0);  // r29
    // PC wrap after reset.
    add_vec(1, 32'hFF,       32'hFFFFFFFC, 1, 0, 0,  0, 0, 0);  // r30
    add_vec(0, 32'h0,        32'h0,        1, 0, 0,  1, 0, 0);  // r31
    add_vec(0, 32'h0,        32'h0,        1, 0, 0,  0, 0, 0);  // r32

    for (int i = 0; i < 30; i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Reset asserted between edges: the outputs must clear immediately.
    @(posedge clk);
    #3;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    sb.delete();
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #3 reset = 1'b1;

    for (int i = 30; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], i);
    end

    repeat (2) @(posedge clk);
    #1;
    check_output("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
